// File: rtl/ts_pkg.sv
// Shared constants, encodings and field layout for receive-side training-sequence handling.
// Imported by the TS decoder, the per-lane monitor and the lane deskew logic.
package ts_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  localparam int LINK_BYTE  = 1;
  localparam int LANE_BYTE  = 2;
  localparam int NFTS_BYTE  = 3;
  localparam int RATE_BYTE  = 4;
  localparam int CTL_BYTE   = 5;
  localparam int ID_FIRST   = 6;
  localparam int ID_LAST    = 15;

  typedef enum logic [1:0] {
    TS_NONE = 2'b00,
    TS_ONE  = 2'b01,
    TS_TWO  = 2'b10,
    TS_BAD  = 2'b11
  } ts_kind_e;

  typedef enum logic {
    ST_IDLE,
    ST_TRACK
  } mon_state_e;

  typedef struct packed {
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic [7:0] nfts;
    logic [7:0] rate_id;
    logic [7:0] train_ctl;
  } ts_fields_t;

  function automatic logic [7:0] get_byte(input logic [127:0] ts, input int idx);
    return ts[8*idx +: 8];
  endfunction

endpackage

// File: rtl/ts_decode.sv
// Combinational TS classifier: TS1/TS2/invalid from COM and identifier bytes,
// plus extraction of the link, lane, N_FTS, rate and control fields.
module ts_decode
  import ts_pkg::*;
(
  input  logic [127:0] ts,
  output ts_kind_e     kind,
  output ts_fields_t   fields
);

  logic all_ts1;
  logic all_ts2;

  // Identifier bytes must be uniform across the whole tail for a type match
  always_comb begin
    all_ts1 = 1'b1;
    all_ts2 = 1'b1;
    for (int k = ID_FIRST; k <= ID_LAST; k++) begin
      if (get_byte(ts, k) != TS1_ID) all_ts1 = 1'b0;
      if (get_byte(ts, k) != TS2_ID) all_ts2 = 1'b0;
    end
  end

  always_comb begin
    kind = TS_BAD;
    if (get_byte(ts, 0) == COM) begin
      if (all_ts1)      kind = TS_ONE;
      else if (all_ts2) kind = TS_TWO;
    end
  end

  assign fields.link_num  = get_byte(ts, LINK_BYTE);
  assign fields.lane_num  = get_byte(ts, LANE_BYTE);
  assign fields.nfts      = get_byte(ts, NFTS_BYTE);
  assign fields.rate_id   = get_byte(ts, RATE_BYTE);
  assign fields.train_ctl = get_byte(ts, CTL_BYTE);

endmodule

// File: rtl/ts_rx_monitor.sv
// Per-lane receive TS monitor: tracks consecutive identical TSs against a held
// reference, flags TS1/TS2 qualification and an idle-gap timeout for the LTSSM.
module ts_rx_monitor
  import ts_pkg::*;
#(
  parameter int CNT_TARGET     = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [127:0]     ts_i,
  input  logic             ts_i_vld,
  output logic [1:0]       ts_type,
  output logic [CNT_W-1:0] ts_cnt,
  output logic             ts1_hit,
  output logic             ts2_hit,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic [7:0]       nfts,
  output logic [7:0]       rate_id,
  output logic [7:0]       train_ctl,
  output logic             link_pad,
  output logic             lane_pad,
  output logic             bad_ts,
  output logic             gap_timeout
);

  localparam int GAP_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(CNT_TARGET);

  ts_kind_e   dec_kind;
  ts_fields_t dec_fields;

  mon_state_e       state_q, state_d;
  ts_kind_e         kind_q, kind_d;
  ts_fields_t       fields_q, fields_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             bad_q, bad_d;
  logic             tmo_q, tmo_d;
  logic             match;

  ts_decode u_decode (
    .ts     (ts_i),
    .kind   (dec_kind),
    .fields (dec_fields)
  );

  // The held type and captured fields double as the comparison reference
  assign match = (dec_kind == kind_q) && (dec_fields == fields_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      kind_q   <= TS_NONE;
      fields_q <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      bad_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      fields_q <= fields_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      bad_q    <= bad_d;
      tmo_q    <= tmo_d;
    end
  end

  // Priority: clr, then a received TS, then idle-gap accounting
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    fields_d = fields_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    bad_d    = 1'b0;
    tmo_d    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      kind_d  = TS_NONE;
      cnt_d   = '0;
      gap_d   = '0;
    end else if (ts_i_vld) begin
      gap_d = '0;
      if (dec_kind == TS_BAD) begin
        state_d = ST_IDLE;
        kind_d  = TS_BAD;
        cnt_d   = '0;
        bad_d   = 1'b1;
      end else if (state_q == ST_TRACK && match) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        state_d  = ST_TRACK;
        kind_d   = dec_kind;
        fields_d = dec_fields;
        cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (TIMEOUT_CYCLES != 0 && gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
      if (gap_d == GAP_MAX && state_q == ST_TRACK) begin
        state_d = ST_IDLE;
        kind_d  = TS_NONE;
        cnt_d   = '0;
        tmo_d   = 1'b1;
      end
    end
  end

  assign ts_type     = kind_q;
  assign ts_cnt      = cnt_q;
  assign ts1_hit     = (kind_q == TS_ONE) && (cnt_q >= CNT_TGT);
  assign ts2_hit     = (kind_q == TS_TWO) && (cnt_q >= CNT_TGT);
  assign link_num    = fields_q.link_num;
  assign lane_num    = fields_q.lane_num;
  assign nfts        = fields_q.nfts;
  assign rate_id     = fields_q.rate_id;
  assign train_ctl   = fields_q.train_ctl;
  assign link_pad    = (fields_q.link_num == PAD);
  assign lane_pad    = (fields_q.lane_num == PAD);
  assign bad_ts      = bad_q;
  assign gap_timeout = tmo_q;

endmodule

// File: tb/tb_ts_rx_monitor.sv
// Directed self-checking bench for ts_rx_monitor with hand-computed expectations.
module tb_ts_rx_monitor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [127:0] ts_i = '0;
  logic         ts_i_vld = 1'b0;
  logic [1:0]   ts_type;
  logic [7:0]   ts_cnt;
  logic         ts1_hit, ts2_hit;
  logic [7:0]   link_num, lane_num, nfts, rate_id, train_ctl;
  logic         link_pad, lane_pad, bad_ts, gap_timeout;

  int checkCount = 0;
  int failCount  = 0;

  logic [127:0] ts1Lane2, ts1Lane3, ts2Pad, badTs;

  ts_rx_monitor #(.CNT_TARGET(8), .CNT_W(8), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ts_i(ts_i), .ts_i_vld(ts_i_vld),
    .ts_type(ts_type), .ts_cnt(ts_cnt), .ts1_hit(ts1_hit), .ts2_hit(ts2_hit),
    .link_num(link_num), .lane_num(lane_num), .nfts(nfts), .rate_id(rate_id),
    .train_ctl(train_ctl), .link_pad(link_pad), .lane_pad(lane_pad),
    .bad_ts(bad_ts), .gap_timeout(gap_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] makeTs(input logic [7:0] com, input logic [7:0] id,
                                          input logic [7:0] link, input logic [7:0] lane,
                                          input logic [7:0] nf, input logic [7:0] rate,
                                          input logic [7:0] ctl);
    logic [127:0] t;
    t = '0;
    t[7:0]   = com;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = nf;
    t[39:32] = rate;
    t[47:40] = ctl;
    for (int k = 6; k < 16; k++) t[8*k +: 8] = id;
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge
  task automatic applyStimulus(input logic [127:0] ts, input logic vld, input logic c);
    ts_i = ts;
    ts_i_vld = vld;
    clr = c;
    @(posedge clk);
    #1;
    ts_i_vld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_type"}, 32'(ts_type), 0);
    checkOutput({tag, "_cnt"}, 32'(ts_cnt), 0);
    checkOutput({tag, "_flags"}, {26'd0, ts1_hit, ts2_hit, link_pad, lane_pad, bad_ts, gap_timeout}, 0);
    checkOutput({tag, "_f0"}, {link_num, lane_num, nfts, rate_id}, 0);
    checkOutput({tag, "_f1"}, 32'(train_ctl), 0);
  endtask

  initial begin
    ts1Lane2 = makeTs(8'hBC, 8'h4A, 8'h00, 8'h02, 8'h1F, 8'h02, 8'h00);
    ts1Lane3 = makeTs(8'hBC, 8'h4A, 8'h00, 8'h03, 8'h1F, 8'h02, 8'h00);
    ts2Pad   = makeTs(8'hBC, 8'h45, 8'hF7, 8'hF7, 8'h20, 8'h06, 8'h01);
    badTs    = makeTs(8'h1C, 8'h4A, 8'h00, 8'h03, 8'h1F, 8'h02, 8'h00);

    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 8 identical TS1s, hit at the 8th
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(ts1Lane2, 1'b1, 1'b0);
      checkOutput($sformatf("run8_cnt%0d", i), 32'(ts_cnt), i);
      checkOutput($sformatf("run8_hit%0d", i), 32'(ts1_hit), (i >= 8) ? 1 : 0);
    end
    checkOutput("run8_type", 32'(ts_type), 1);
    checkOutput("run8_lane", 32'(lane_num), 32'h02);
    checkOutput("run8_nfts", 32'(nfts), 32'h1F);
    checkOutput("run8_ts2hit", 32'(ts2_hit), 0);

    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("clr_cnt", 32'(ts_cnt), 0);
    checkOutput("clr_type", 32'(ts_type), 0);
    checkOutput("clr_keep_lane", 32'(lane_num), 32'h02);

    // 5 TS1s, lane change restarts count, then 7 more to reach target
    for (int i = 1; i <= 5; i++) applyStimulus(ts1Lane2, 1'b1, 1'b0);
    checkOutput("chg_pre_cnt", 32'(ts_cnt), 5);
    applyStimulus(ts1Lane3, 1'b1, 1'b0);
    checkOutput("chg_cnt", 32'(ts_cnt), 1);
    checkOutput("chg_lane", 32'(lane_num), 32'h03);
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(ts1Lane3, 1'b1, 1'b0);
      checkOutput($sformatf("chg_cnt%0d", i), 32'(ts_cnt), i);
      checkOutput($sformatf("chg_hit%0d", i), 32'(ts1_hit), (i >= 8) ? 1 : 0);
    end

    // Invalid TS: pulse, type 11, fields held
    applyStimulus(badTs, 1'b1, 1'b0);
    checkOutput("bad_pulse", 32'(bad_ts), 1);
    checkOutput("bad_type", 32'(ts_type), 3);
    checkOutput("bad_cnt", 32'(ts_cnt), 0);
    checkOutput("bad_hit", 32'(ts1_hit), 0);
    checkOutput("bad_lane", 32'(lane_num), 32'h03);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("bad_pulse_end", 32'(bad_ts), 0);
    checkOutput("bad_type_hold", 32'(ts_type), 3);
    applyStimulus(ts1Lane3, 1'b1, 1'b0);
    checkOutput("after_bad_cnt", 32'(ts_cnt), 1);

    // TS2 with PAD fields, then idle timeout at cycle 1024
    applyStimulus(ts2Pad, 1'b1, 1'b0);
    checkOutput("pad_type", 32'(ts_type), 2);
    checkOutput("pad_cnt", 32'(ts_cnt), 1);
    checkOutput("pad_flags", {30'd0, link_pad, lane_pad}, 3);
    checkOutput("pad_rate", 32'(rate_id), 32'h06);
    for (int i = 1; i <= 1023; i++) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("gap_1023_tmo", 32'(gap_timeout), 0);
    checkOutput("gap_1023_type", 32'(ts_type), 2);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("gap_1024_tmo", 32'(gap_timeout), 1);
    checkOutput("gap_1024_cnt", 32'(ts_cnt), 0);
    checkOutput("gap_1024_type", 32'(ts_type), 0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("gap_tmo_end", 32'(gap_timeout), 0);
    checkOutput("gap_keep_pad", {30'd0, link_pad, lane_pad}, 3);

    // TS arriving on the expiring cycle suppresses the timeout
    applyStimulus(ts2Pad, 1'b1, 1'b0);
    for (int i = 1; i <= 1023; i++) applyStimulus('0, 1'b0, 1'b0);
    applyStimulus(ts2Pad, 1'b1, 1'b0);
    checkOutput("race_tmo", 32'(gap_timeout), 0);
    checkOutput("race_cnt", 32'(ts_cnt), 2);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("race_tmo_next", 32'(gap_timeout), 0);

    // Saturation at 255 with hit held
    for (int i = 3; i <= 300; i++) applyStimulus(ts2Pad, 1'b1, 1'b0);
    checkOutput("sat_cnt", 32'(ts_cnt), 255);
    checkOutput("sat_hit", 32'(ts2_hit), 1);
    checkOutput("sat_ts1hit", 32'(ts1_hit), 0);

    // clr beats a simultaneous TS after 7 TS1s
    applyStimulus('0, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) applyStimulus(ts1Lane2, 1'b1, 1'b0);
    checkOutput("clrv_pre_cnt", 32'(ts_cnt), 7);
    checkOutput("clrv_pre_hit", 32'(ts1_hit), 0);
    applyStimulus(ts1Lane2, 1'b1, 1'b1);
    checkOutput("clrv_cnt", 32'(ts_cnt), 0);
    checkOutput("clrv_type", 32'(ts_type), 0);
    checkOutput("clrv_hit", 32'(ts1_hit), 0);
    applyStimulus(ts1Lane2, 1'b1, 1'b0);
    checkOutput("clrv_restart", 32'(ts_cnt), 1);
    checkOutput("clrv_restart_hit", 32'(ts1_hit), 0);

    // Asynchronous reset mid-stream
    for (int i = 1; i <= 3; i++) applyStimulus(ts2Pad, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("areset");
    @(negedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
